// File: rtl/sprite_mover.sv
`default_nettype none
// ============================================================================
// sprite_mover : per-frame sprite position generator that bounces off edges
// Rev 1.0
// ============================================================================
module sprite_mover #(
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int SPRITE_SIZE = 8,
   parameter int STEP        = 1,
   parameter int INIT_X      = 0,
   parameter int INIT_Y      = 0
) (
   input  logic        i_pix_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_horz_coord,
   input  logic [15:0] i_vert_coord,
   input  logic        i_enable,
   output logic [15:0] o_x_coord,
   output logic [15:0] o_y_coord,
   output logic        o_frame_tick,
   output logic        o_bounce_x,
   output logic        o_bounce_y,
   output logic [15:0] o_frame_count
);

   localparam logic [15:0] c_max_x    = 16'(SCREEN_W - SPRITE_SIZE);
   localparam logic [15:0] c_max_y    = 16'(SCREEN_H - SPRITE_SIZE);
   localparam logic [15:0] c_step     = 16'(STEP);
   localparam logic [15:0] c_screen_h = 16'(SCREEN_H);
   localparam logic [15:0] c_init_x   = 16'(INIT_X);
   localparam logic [15:0] c_init_y   = 16'(INIT_Y);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_MOVE_X = 2'd1,
      S_MOVE_Y = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        vblank_q, vblank_d;
   logic        frame_start;
   logic [15:0] x_q, x_d, y_q, y_d;
   logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic        tick_q, tick_d;
   logic        bounce_x_q, bounce_x_d, bounce_y_q, bounce_y_d;
   logic [15:0] count_q, count_d;

   // Horizontal beam position plays no part in per-frame motion.
   logic unused_horz;
   assign unused_horz = ^i_horz_coord;

   // Returns {bounce, new_dir, new_pos}; clamping keeps pos inside [0, lim].
   function automatic logic [17:0] axis_step(input logic [15:0] pos,
                                             input logic        dir,
                                             input logic [15:0] lim);
      logic [17:0] r;
      if (!dir) begin
         if (pos + c_step >= lim) r = {1'b1, 1'b1, lim};
         else                     r = {1'b0, 1'b0, pos + c_step};
      end else begin
         if (pos <= c_step)       r = {1'b1, 1'b0, 16'd0};
         else                     r = {1'b0, 1'b1, pos - c_step};
      end
      return r;
   endfunction

   assign vblank_d    = (i_vert_coord >= c_screen_h);
   assign frame_start = vblank_d && !vblank_q;

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      dir_x_d    = dir_x_q;
      dir_y_d    = dir_y_q;
      tick_d     = 1'b0;
      bounce_x_d = 1'b0;
      bounce_y_d = 1'b0;
      count_d    = count_q;
      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d = S_MOVE_X;
               tick_d  = 1'b1;
               count_d = count_q + 16'd1;
            end
         end
         S_MOVE_X: begin
            state_d = S_MOVE_Y;
            if (i_enable) {bounce_x_d, dir_x_d, x_d} = axis_step(x_q, dir_x_q, c_max_x);
         end
         S_MOVE_Y: begin
            state_d = S_IDLE;
            if (i_enable) {bounce_y_d, dir_y_d, y_d} = axis_step(y_q, dir_y_q, c_max_y);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // vblank resets high so a release inside blanking cannot fake a frame start.
   always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         vblank_q   <= 1'b1;
         x_q        <= c_init_x;
         y_q        <= c_init_y;
         dir_x_q    <= 1'b0;
         dir_y_q    <= 1'b0;
         tick_q     <= 1'b0;
         bounce_x_q <= 1'b0;
         bounce_y_q <= 1'b0;
         count_q    <= 16'd0;
      end else begin
         state_q    <= state_d;
         vblank_q   <= vblank_d;
         x_q        <= x_d;
         y_q        <= y_d;
         dir_x_q    <= dir_x_d;
         dir_y_q    <= dir_y_d;
         tick_q     <= tick_d;
         bounce_x_q <= bounce_x_d;
         bounce_y_q <= bounce_y_d;
         count_q    <= count_d;
      end
   end

   assign o_x_coord     = x_q;
   assign o_y_coord     = y_q;
   assign o_frame_tick  = tick_q;
   assign o_bounce_x    = bounce_x_q;
   assign o_bounce_y    = bounce_y_q;
   assign o_frame_count = count_q;

endmodule
`default_nettype wire

// File: doc/sprite_mover.md
# sprite_mover

Generates the on-screen position of one sprite and bounces it off the screen edges. The block sits directly upstream of the sprite renderer, and its `o_x_coord`/`o_y_coord` drive the renderer's sprite-position inputs. It watches the same VGA beam coordinates as the renderer and advances the sprite once per frame. Position updates happen only during vertical blanking, so the sprite never tears mid-frame.

## Interface
- `SCREEN_W`, 640, active pixels per line
- `SCREEN_H`, 480, active lines per frame
- `SPRITE_SIZE`, 8, sprite edge length in pixels (square)
- `STEP`, 1, pixels moved per axis per frame; 1 ≤ STEP < SCREEN_H − SPRITE_SIZE
- `INIT_X`, 0, reset X; 0 ≤ INIT_X ≤ SCREEN_W − SPRITE_SIZE
- `INIT_Y`, 0, reset Y; 0 ≤ INIT_Y ≤ SCREEN_H − SPRITE_SIZE
- `i_pix_clk`  in  1  pixel clock; the only clock
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_horz_coord`  in  16  current beam column (unused except for lint)
- `i_vert_coord`  in  16  current beam line
- `i_enable`  in  1  1 = move on each frame; 0 = freeze position
- `o_x_coord`  out  16  sprite left edge, registered
- `o_y_coord`  out  16  sprite top edge, registered
- `o_frame_tick`  out  1  one-cycle pulse at the start of vertical blanking
- `o_bounce_x`  out  1  one-cycle pulse when X direction flips
- `o_bounce_y`  out  1  one-cycle pulse when Y direction flips
- `o_frame_count`  out  16  frames seen since reset; wraps 0xFFFF→0

## Operation
- Constants: MAX_X = SCREEN_W − SPRITE_SIZE; MAX_Y = SCREEN_H − SPRITE_SIZE.
- Blanking detect:
  - `vblank_q` is registered as (`i_vert_coord` ≥ SCREEN_H).
  - A frame start is the cycle where that compare is 1 while `vblank_q` = 0.
- Direction registers `dir_x` and `dir_y`: 0 = increasing, 1 = decreasing.
- FSM states:
  - IDLE: on frame start, go to MOVE_X. Otherwise stay.
  - MOVE_X: apply the X update (rule below), then go to MOVE_Y.
  - MOVE_Y: apply the Y update (same rule on the Y registers with MAX_Y), then go to IDLE.
- Update rule for X when `i_enable` = 1:
  - `dir_x` = 0 and x + STEP ≥ MAX_X: x ← MAX_X, `dir_x` ← 1, pulse `o_bounce_x`.
  - `dir_x` = 0 otherwise: x ← x + STEP.
  - `dir_x` = 1 and x ≤ STEP: x ← 0, `dir_x` ← 0, pulse `o_bounce_x`.
  - `dir_x` = 1 otherwise: x ← x − STEP.
- Arithmetic is 16-bit unsigned. Clamping guarantees no wrap, and the position stays in [0, MAX] at all times.
- `i_enable` = 0:
  - The FSM still walks IDLE→MOVE_X→MOVE_Y→IDLE.
  - `o_frame_tick` and `o_frame_count` still update.
  - Position and direction are held, and no bounce pulses fire.
- Corner hit: `o_bounce_x` and `o_bounce_y` fire in consecutive cycles, never in the same cycle.
- A frame start seen outside IDLE is ignored; this cannot happen with legal VGA timing.

## Timing
- Reset values (asynchronous, while `i_rst_n` = 0):
  - x = INIT_X, y = INIT_Y, `dir_x` = `dir_y` = 0.
  - `vblank_q` = 1, so no tick occurs if reset releases inside blanking.
  - State = IDLE.
  - `o_frame_tick` = `o_bounce_x` = `o_bounce_y` = 0; `o_frame_count` = 0.
- Edge E0: the frame start is sampled. At E0:
  - `o_frame_tick` ← 1.
  - `o_frame_count` increments.
  - State ← MOVE_X.
- Edge E1:
  - `o_frame_tick` ← 0.
  - `o_x_coord` takes its new value; `o_bounce_x` is set for one cycle if X bounced.
  - State ← MOVE_Y.
- Edge E2:
  - `o_y_coord` takes its new value; `o_bounce_y` is set for one cycle if Y bounced.
  - `o_bounce_x` ← 0.
  - State ← IDLE.
- Edge E3: `o_bounce_y` ← 0.
- Latency from frame start to final position is 3 edges, well inside blanking.
- Reset asserted mid-sequence returns every register to its reset value immediately. The first tick after release occurs only after `i_vert_coord` re-enters the active area and then blanking again.

## Test plan
- Reset with INIT_X=INIT_Y=0, enable=1, STEP=1; run 3 frames → `o_frame_count` = 3, `o_x_coord` = 3, `o_y_coord` = 3; `o_frame_tick` is exactly 1 cycle wide per frame.
- INIT_X=630, INIT_Y=100, STEP=4 → frame 1: x = 632 with `o_bounce_x` pulse; frame 2: x = 628. Y goes 104, then 108.
- INIT_X=0 and `dir_x` forced to 1 by prior travel to x = 2, STEP=4 → x = 0, one `o_bounce_x` pulse, then x = 4 on the next frame.
- Corner: INIT_X=631, INIT_Y=471, STEP=1 → x = 632 and y = 472; `o_bounce_x` at E1 and `o_bounce_y` at E2, one cycle apart; both directions then decrease.
- enable=0 for 5 frames → positions and directions unchanged, `o_frame_count` += 5, no bounce pulses.
- Assert `i_rst_n` low at E1 of a frame, release mid-blanking → outputs return to INIT values at once; no tick until the next active-then-blanking transition.
